// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes and the frame FSM state encoding,
// used by both the transmitter and the matching receiver.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  // Mode 2'b11 is deliberately treated as no parity.
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count. Shared by the UART transmitter and receiver.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            en,
  output logic [$clog2(CLKS_PER_BIT)-1:0] baud_cnt,
  output logic                            bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  always_ff @(posedge clk) begin
    if (rst || clr)
      baud_cnt <= '0;
    else if (en)
      baud_cnt <= (baud_cnt == TERM) ? '0 : baud_cnt + 1'b1;
  end

  assign bit_tick = en && (baud_cnt == TERM);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with run-time parity and valid/ready input.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  input  logic [1:0]           parity_mode,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_req,
`endif
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] TERM      = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [1:0]           mode;
  logic                 par_bit;
  logic [BW-1:0]        bit_cnt;
  logic [CW-1:0]        baud_cnt;
  logic                 bit_tick;
  logic                 accept;
  logic                 last_stop;
  logic                 brk_go;
  logic                 brk_clr;

`ifdef UART_TX_BREAK_EN
  logic brk_rel;
  assign brk_go  = break_req;
  // Hold the bit counter at zero while the line is held low so the
  // release period is exactly one full bit.
  assign brk_clr = (state == BREAK) && !brk_rel;
`else
  assign brk_go  = 1'b0;
  assign brk_clr = 1'b0;
`endif

  assign last_stop = (state == STOP) && (bit_cnt == LAST_STOP) && (baud_cnt == TERM);
  assign tx_ready  = ((state == IDLE) && !brk_go) || last_stop;
  assign accept    = tx_valid && tx_ready;
  assign busy      = (state != IDLE);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept || brk_clr),
    .en       (busy),
    .baud_cnt (baud_cnt),
    .bit_tick (bit_tick)
  );

  // tx is driven with the value of the state being entered, so each bit is
  // on the line for exactly the cycles its state is resident.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      bit_cnt   <= '0;
      shift_reg <= '0;
      mode      <= PAR_NONE;
      par_bit   <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_rel   <= 1'b0;
`endif
    end else if (accept) begin
      state     <= START;
      tx        <= 1'b0;
      shift_reg <= tx_data;
      mode      <= parity_mode;
      par_bit   <= (^tx_data) ^ (parity_mode == PAR_ODD);
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (brk_go) begin
            state <= BREAK;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_tick) begin
            state   <= DATA;
            tx      <= shift_reg[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (par_enabled(mode)) begin
                state <= PARITY;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_STOP) begin
              state <= IDLE;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          if (!brk_rel) begin
            if (!break_req) begin
              brk_rel <= 1'b1;
              tx      <= 1'b1;
            end
          end else if (bit_tick) begin
            state   <= IDLE;
            brk_rel <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: stimulus queues per-cycle expected line
// images, a monitor pops one per observed frame start and checks every cycle.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d0  = '0;
  logic [4:0] d1  = '0;
  logic       v0  = 1'b0;
  logic       v1  = 1'b0;
  logic [1:0] pm0 = '0;
  logic [1:0] pm1 = '0;
  logic       brk = 1'b0;
  logic       tx0, rdy0, busy0;
  logic       tx1, rdy1, busy1;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0), .parity_mode(pm0),
`ifdef UART_TX_BREAK_EN
    .break_req(brk),
`endif
    .tx_ready(rdy0), .tx(tx0), .busy(busy0)
  );

  uart_tx_frame #(.DATA_BITS(5), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .parity_mode(pm1),
`ifdef UART_TX_BREAK_EN
    .break_req(1'b0),
`endif
    .tx_ready(rdy1), .tx(tx1), .busy(busy1)
  );

  typedef struct {
    int          id;
    logic [63:0] w;
    int          len;
    logic        rdy_last;
  } exp_t;

  exp_t q[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   exp_acc0 = 0;
  int   exp_acc1 = 0;
  int   to_err   = 0;
  logic done     = 1'b0;

  // bits[0] is the first bit on the line; each bit spans 4 cycles.
  function automatic exp_t mk(input int id, input logic [15:0] bits, input int nb);
    exp_t e;
    e.id = id; e.w = '0; e.len = nb * 4; e.rdy_last = 1'b1;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < 4; c++)
        e.w[b*4+c] = bits[b];
    return e;
  endfunction

  task automatic wait_rdy(input int id);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!((id == 0) ? rdy0 : rdy1) && k < 200);
    if (!((id == 0) ? rdy0 : rdy1)) to_err++;
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy0 || busy1) && k < 200);
    if (busy0 || busy1) to_err++;
    @(negedge clk);
  endtask

  task automatic send(input int id, input logic [7:0] d, input logic [1:0] m);
    @(posedge clk); #1;
    if (id == 0) begin v0 = 1'b1; d0 = d; pm0 = m; end
    else         begin v1 = 1'b1; d1 = d[4:0]; pm1 = m; end
    wait_rdy(id);
    @(posedge clk); #1;
    // Scramble inputs after the accept; the frame must use the captured copy.
    if (id == 0) begin v0 = 1'b0; d0 = ~d; pm0 = ~m; exp_acc0++; end
    else         begin v1 = 1'b0; d1 = ~d[4:0]; pm1 = ~m; exp_acc1++; end
  endtask

  // Monitor / scoreboard
  initial begin : mon
    exp_t cur[2];
    int   idx[2];
    logic act[2];
    int   n_acc[2];
    logic t, b, r, v, exp_r;
    act = '{1'b0, 1'b0};
    idx = '{0, 0};
    n_acc = '{0, 0};
    forever begin
      @(negedge clk);
      if (done) break;
      for (int i = 0; i < 2; i++) begin
        t = (i == 0) ? tx0 : tx1;
        b = (i == 0) ? busy0 : busy1;
        r = (i == 0) ? rdy0 : rdy1;
        v = (i == 0) ? v0 : v1;
        if (rst) begin
          act[i] = 1'b0;
          continue;
        end
        n_chk++;
        if (act[i]) begin
          exp_r = cur[i].rdy_last && (idx[i] == cur[i].len - 1);
          if (t !== cur[i].w[idx[i]] || b !== 1'b1 || r !== exp_r) begin
            n_fail++;
            $display("FAIL frame dut%0d cyc %0d: tx=%b busy=%b ready=%b, want tx=%b busy=1 ready=%b",
                     i, idx[i], t, b, r, cur[i].w[idx[i]], exp_r);
          end
          idx[i]++;
          if (idx[i] == cur[i].len) act[i] = 1'b0;
        end else begin
          exp_r = (i == 0) ? !brk : 1'b1;
          if (t !== 1'b1 || b !== 1'b0 || r !== exp_r) begin
            n_fail++;
            $display("FAIL idle dut%0d: tx=%b busy=%b ready=%b, want tx=1 busy=0 ready=%b",
                     i, t, b, r, exp_r);
          end
        end
        if ((v && r) || (i == 0 && brk && !b && !act[i])) begin
          if (v && r) n_acc[i]++;
          if (q.size() == 0 || q[0].id != i) begin
            n_chk++; n_fail++;
            $display("FAIL start dut%0d: frame started with no matching expectation queued", i);
          end else begin
            cur[i] = q.pop_front();
            idx[i] = 0;
            act[i] = 1'b1;
          end
        end
      end
    end
    n_chk++;
    if (n_acc[0] != exp_acc0 || n_acc[1] != exp_acc1) begin
      n_fail++;
      $display("FAIL accepts: got %0d/%0d, want %0d/%0d", n_acc[0], n_acc[1], exp_acc0, exp_acc1);
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected frames never started, want 0", q.size());
    end
    n_chk++;
    if (to_err != 0) begin
      n_fail++;
      $display("FAIL timeout: %0d waits expired, want 0", to_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Stimulus
  initial begin : stim
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // A5 even/odd/none, and mode 11 treated as none
    q.push_back(mk(0, 16'b10101001010, 11));
    send(0, 8'hA5, 2'b01); wait_idle();
    q.push_back(mk(0, 16'b11101001010, 11));
    send(0, 8'hA5, 2'b10); wait_idle();
    q.push_back(mk(0, 16'b1101001010, 10));
    send(0, 8'hA5, 2'b00); wait_idle();
    q.push_back(mk(0, 16'b1001111000, 10));
    send(0, 8'h3C, 2'b11); wait_idle();

    // Back-to-back with valid held high
    q.push_back(mk(0, 16'b1000000000, 10));
    q.push_back(mk(0, 16'b1111111110, 10));
    @(posedge clk); #1;
    v0 = 1'b1; d0 = 8'h00; pm0 = 2'b00;
    wait_rdy(0);
    @(posedge clk); #1;
    d0 = 8'hFF;
    wait_rdy(0);
    @(posedge clk); #1;
    v0 = 1'b0;
    exp_acc0 += 2;
    wait_idle();

    // 5 data bits, 2 stop bits, even parity
    q.push_back(mk(1, 16'b111111110, 9));
    send(1, 8'h1F, 2'b01); wait_idle();

    // Reset during the third data bit, then a clean frame
    q.push_back(mk(0, 16'b1010110100, 10));
    send(0, 8'h5A, 2'b00);
    repeat (13) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.push_back(mk(0, 16'b1001111000, 10));
    send(0, 8'h3C, 2'b00); wait_idle();

`ifdef UART_TX_BREAK_EN
    begin
      exp_t e;
      e.id = 0; e.w = '0; e.len = 24; e.rdy_last = 1'b0;
      for (int c = 20; c < 24; c++) e.w[c] = 1'b1;
      q.push_back(e);
    end
    @(posedge clk); #1 brk = 1'b1;
    repeat (20) @(posedge clk);
    #1 brk = 1'b0;
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
